// File: rtl/rv_bringup_ctrl.sv
// Bring-up controller for rv_cpu: sequences the core reset, counts RUN cycles and
// commits, detects halt (self-loop) or timeout, and optionally keeps a trace of
// the most recent commits.
// Optional feature macro: BRINGUP_TRACE_EN (trace buffer, trace_count, trace_rd_*).
module rv_bringup_ctrl #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned CNT_W          = 32,
   parameter int unsigned RST_CYCLES     = 5,
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned HALT_REPEAT    = 3,
   parameter int unsigned TRACE_DEPTH    = 16,
   localparam int unsigned IW            = $clog2(TRACE_DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            core_rst_n,
   input  logic            commit_valid,
   input  logic [XLEN-1:0] commit_pc,
   input  logic [31:0]     commit_instr,
   output logic            busy,
   output logic            done,
   output logic            halted,
   output logic            timed_out,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instr_count,
   output logic [IW:0]     trace_count,
   input  logic [IW-1:0]   trace_rd_idx,
   output logic [XLEN-1:0] trace_rd_pc,
   output logic [31:0]     trace_rd_instr
);

   localparam int unsigned HW = $clog2(RST_CYCLES + 1);
   localparam int unsigned RW = $clog2(HALT_REPEAT + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HOLD    = 3'd1,
      RUN     = 3'd2,
      HALTED  = 3'd3,
      TIMEOUT = 3'd4
   } state_t;

   state_t          state, state_nx;
   logic [HW-1:0]   hold_cnt;
   logic [RW-1:0]   rep_cnt;
   logic [XLEN-1:0] last_pc;
   logic            same_pc, halt_hit, timeout_hit, enter_hold;

   // Halt/timeout detection for the current RUN cycle
   always_comb begin
      same_pc     = (rep_cnt != '0) && (commit_pc == last_pc);
      halt_hit    = (state == RUN) && commit_valid && same_pc &&
                    (rep_cnt == RW'(HALT_REPEAT - 1));
      timeout_hit = (state == RUN) && (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
   end

   // Next-state logic; halt takes priority over timeout
   always_comb begin
      state_nx   = state;
      enter_hold = 1'b0;
      case (state)
         IDLE:    if (start) state_nx = HOLD;
         HOLD:    if (hold_cnt == HW'(RST_CYCLES - 1)) state_nx = RUN;
         RUN: begin
            if (halt_hit)         state_nx = HALTED;
            else if (timeout_hit) state_nx = TIMEOUT;
         end
         HALTED:  if (start) state_nx = HOLD;
         TIMEOUT: if (start) state_nx = HOLD;
         default: state_nx = IDLE;
      endcase
      enter_hold = (state_nx == HOLD) && (state != HOLD);
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // Registered status outputs decoded from the next state
   always_ff @(posedge clk) begin
      if (!rst) begin
         core_rst_n <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         halted     <= 1'b0;
         timed_out  <= 1'b0;
      end else begin
         core_rst_n <= (state_nx == RUN);
         busy       <= (state_nx == HOLD) || (state_nx == RUN);
         done       <= (state_nx == HALTED) || (state_nx == TIMEOUT);
         halted     <= (state_nx == HALTED);
         timed_out  <= (state_nx == TIMEOUT);
      end
   end

   // Core reset hold timer
   always_ff @(posedge clk) begin
      if (!rst || enter_hold) hold_cnt <= '0;
      else if (state == HOLD) hold_cnt <= hold_cnt + HW'(1);
   end

   // Run counters and same-PC repeat tracking
   always_ff @(posedge clk) begin
      if (!rst || enter_hold) begin
         cycle_count <= '0;
         instr_count <= '0;
         rep_cnt     <= '0;
         last_pc     <= '0;
      end else if (state == RUN) begin
         if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
         if (commit_valid) begin
            if (instr_count != '1) instr_count <= instr_count + CNT_W'(1);
            last_pc <= commit_pc;
            if (!same_pc)                          rep_cnt <= RW'(1);
            else if (rep_cnt != RW'(HALT_REPEAT)) rep_cnt <= rep_cnt + RW'(1);
         end
      end
   end

`ifdef BRINGUP_TRACE_EN
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
   } trace_ent_t;

   trace_ent_t    mem [TRACE_DEPTH];
   logic [IW-1:0] wr_ptr;
   logic [IW-1:0] rd_phys;
   logic          trace_wr;

   // Oldest-first read index mapping once the buffer has wrapped
   always_comb begin
      trace_wr = (state == RUN) && commit_valid;
      rd_phys  = (trace_count == (IW+1)'(TRACE_DEPTH)) ? (wr_ptr + trace_rd_idx) : trace_rd_idx;
   end

   // Write pointer and fill level
   always_ff @(posedge clk) begin
      if (!rst || enter_hold) begin
         wr_ptr      <= '0;
         trace_count <= '0;
      end else if (trace_wr) begin
         wr_ptr <= wr_ptr + IW'(1);
         if (trace_count != (IW+1)'(TRACE_DEPTH)) trace_count <= trace_count + (IW+1)'(1);
      end
   end

   // Trace storage (no reset needed; validity tracked by trace_count)
   always_ff @(posedge clk) begin
      if (trace_wr) mem[wr_ptr] <= '{pc: commit_pc, instr: commit_instr};
   end

   // Registered read port; entries beyond the fill level read as zero
   always_ff @(posedge clk) begin
      if (!rst) begin
         trace_rd_pc    <= '0;
         trace_rd_instr <= '0;
      end else if ({1'b0, trace_rd_idx} < trace_count) begin
         trace_rd_pc    <= mem[rd_phys].pc;
         trace_rd_instr <= mem[rd_phys].instr;
      end else begin
         trace_rd_pc    <= '0;
         trace_rd_instr <= '0;
      end
   end
`else
   logic unused_trace;
   assign unused_trace   = ^{trace_rd_idx, commit_instr};
   assign trace_count    = '0;
   assign trace_rd_pc    = '0;
   assign trace_rd_instr = '0;
`endif

endmodule
